// File: rtl/aes_mix_pkg.sv
// aes_mix_pkg: shared types and constants for the byte-serial MixColumns
// sequencer (mixcol_ctrl) and its datapath (mixcolumn_8).
//   mix_state_e  : sequencer states FILL / FEED / CAP
//   MIX_EN_*     : accumulator enable masks handed to mixcolumn_8
//   COL_BYTES    : bytes per state column
//   BLK_COLS     : columns per AES block
//   xtime()      : GF(2^8) multiply-by-2 with the AES polynomial
package aes_mix_pkg;

    typedef enum logic [1:0] {
        FILL = 2'd0,
        FEED = 2'd1,
        CAP  = 2'd2
    } mix_state_e;

    localparam logic [7:0] MIX_EN_FIRST = 8'h00;
    localparam logic [7:0] MIX_EN_ACC   = 8'hFF;

    localparam int COL_BYTES = 4;
    localparam int BLK_COLS  = 4;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/mixcolumn_8.sv
// mixcolumn_8: byte-serial MixColumns datapath.
// One column byte per clock on din (byte 0 first). Four accumulators rotate
// each cycle and add a fixed GF multiple of din, so after four cycles each
// accumulator holds one row of the MixColumns product.
//   clk        : clock, rising edge
//   rst        : synchronous, active-high clear
//   din        : column byte
//   en         : mask on the rotated accumulator (00 on byte 0 starts a column)
//   dout0..3   : mixed column bytes, valid the cycle after the 4th din
module mixcolumn_8
    import aes_mix_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] din,
    input  logic [7:0] en,
    output logic [7:0] dout0,
    output logic [7:0] dout1,
    output logic [7:0] dout2,
    output logic [7:0] dout3
);

    logic [7:0] acc_q [4];
    logic [7:0] din_x2;
    logic [7:0] din_x3;

    assign din_x2 = xtime(din);
    assign din_x3 = din_x2 ^ din;

    // A term entering slot p at byte k lands in slot p-(3-k); with slot
    // coefficients {1,1,3,2} this reproduces the circulant rows [2 3 1 1].
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) acc_q[i] <= 8'h00;
        end else begin
            acc_q[0] <= (acc_q[1] & en) ^ din;
            acc_q[1] <= (acc_q[2] & en) ^ din;
            acc_q[2] <= (acc_q[3] & en) ^ din_x3;
            acc_q[3] <= (acc_q[0] & en) ^ din_x2;
        end
    end

    assign dout0 = acc_q[0];
    assign dout1 = acc_q[1];
    assign dout2 = acc_q[2];
    assign dout3 = acc_q[3];

endmodule

// File: rtl/mixcol_ctrl.sv
// mixcol_ctrl: byte-serial sequencer around mixcolumn_8.
// Buffers one column from the input stream, feeds it to mixcolumn_8 in four
// back-to-back cycles, captures the mixed column and replays it on the
// output stream. Draining overlaps filling of the next column.
// Optional feature macro: AES_MIXCOL_BYPASS_EN (per-block unmixed pass-through).
//   clk, rst_n                   : clock, synchronous active-low reset
//   in_valid/in_ready/in_data    : column-major state byte stream
//   bypass                       : last-round flag, sampled at block start
//   out_valid/out_ready/out_data : mixed byte stream
//   out_last                     : marks byte 15 of a block
//   busy                         : not idle in FILL or output still pending
module mixcol_ctrl
    import aes_mix_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    input  logic       bypass,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       out_last,
    output logic       busy
);

    mix_state_e state_q;
    logic [1:0] k_q;        // FEED byte index
    logic [1:0] fidx_q;     // byte index within the column being filled
    logic [1:0] icol_q;     // input column within the block
    logic [1:0] rd_q;       // obuf drain index
    logic [3:0] ocnt_q;     // output byte index within the block
    logic [7:0] ibuf_q [COL_BYTES];
    logic [7:0] obuf_q [COL_BYTES];
    logic       obuf_vld_q;
    logic       out_valid_q;
    logic       out_last_q;
    logic [7:0] out_data_q;

    logic [7:0] mix_din, mix_en;
    logic [7:0] dout [COL_BYTES];
    logic [7:0] cap_d [COL_BYTES];
    logic       in_fire, out_fire;
    logic [1:0] rd_nxt_d;

`ifdef AES_MIXCOL_BYPASS_EN
    logic byp_q;
`else
    logic unused_cfg;
    assign unused_cfg = bypass ^ (^icol_q);
`endif

    // The 4th byte of a column is held off while the previous column is
    // still draining, since FEED cannot stall once started.
    assign in_ready  = rst_n && (state_q == FILL) && !((fidx_q == 2'd3) && obuf_vld_q);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid_q && out_ready;
    assign rd_nxt_d  = rd_q + 2'd1;

    assign mix_din = (state_q == FEED) ? ibuf_q[k_q] : 8'h00;
    assign mix_en  = ((state_q == FEED) && (k_q != 2'd0)) ? MIX_EN_ACC : MIX_EN_FIRST;

    mixcolumn_8 u_mix (
        .clk   (clk),
        .rst   (~rst_n),
        .din   (mix_din),
        .en    (mix_en),
        .dout0 (dout[0]),
        .dout1 (dout[1]),
        .dout2 (dout[2]),
        .dout3 (dout[3])
    );

    always_comb begin
        for (int i = 0; i < COL_BYTES; i++) begin
`ifdef AES_MIXCOL_BYPASS_EN
            cap_d[i] = byp_q ? ibuf_q[i] : dout[i];
`else
            cap_d[i] = dout[i];
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= FILL;
            k_q         <= 2'd0;
            fidx_q      <= 2'd0;
            icol_q      <= 2'd0;
            rd_q        <= 2'd0;
            ocnt_q      <= 4'd0;
            obuf_vld_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= 8'h00;
            for (int i = 0; i < COL_BYTES; i++) begin
                ibuf_q[i] <= 8'h00;
                obuf_q[i] <= 8'h00;
            end
`ifdef AES_MIXCOL_BYPASS_EN
            byp_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                FILL: begin
                    if (in_fire) begin
                        ibuf_q[fidx_q] <= in_data;
`ifdef AES_MIXCOL_BYPASS_EN
                        if ((fidx_q == 2'd0) && (icol_q == 2'd0)) byp_q <= bypass;
`endif
                        if (fidx_q == 2'd3) begin
                            fidx_q  <= 2'd0;
                            icol_q  <= icol_q + 2'd1;
                            k_q     <= 2'd0;
                            state_q <= FEED;
                        end else begin
                            fidx_q <= fidx_q + 2'd1;
                        end
                    end
                end
                FEED: begin
                    k_q <= k_q + 2'd1;
                    if (k_q == 2'd3) state_q <= CAP;
                end
                CAP: begin
                    // obuf is known empty here, so no drain can coincide.
                    obuf_q      <= cap_d;
                    obuf_vld_q  <= 1'b1;
                    rd_q        <= 2'd0;
                    out_valid_q <= 1'b1;
                    out_data_q  <= cap_d[0];
                    out_last_q  <= (ocnt_q == 4'd15);
                    state_q     <= FILL;
                end
                default: state_q <= FILL;
            endcase

            if (out_fire) begin
                ocnt_q <= ocnt_q + 4'd1;
                if (rd_q == 2'd3) begin
                    out_valid_q <= 1'b0;
                    out_last_q  <= 1'b0;
                    obuf_vld_q  <= 1'b0;
                end else begin
                    rd_q       <= rd_nxt_d;
                    out_data_q <= obuf_q[rd_nxt_d];
                    out_last_q <= (ocnt_q == 4'd14);
                end
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign busy      = (state_q != FILL) || obuf_vld_q;

endmodule

// File: tb/tb_mixcol_ctrl.sv
module tb_mixcol_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       bypass = 1'b0;
    logic       out_ready = 1'b1;
    wire        in_ready, out_valid, out_last, busy;
    wire  [7:0] out_data;

    mixcol_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .bypass    (bypass),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Hand-computed MixColumns vectors
    localparam logic [31:0] COL_A = 32'hdb135345, MIX_A = 32'h8e4da1bc;
    localparam logic [31:0] COL_B = 32'hf20a225c, MIX_B = 32'h9fdc589d;
    localparam logic [31:0] COL_C = 32'h01010101, MIX_C = 32'h01010101;
    localparam logic [31:0] COL_D = 32'hc6c6c6c6, MIX_D = 32'hc6c6c6c6;

    int vectors = 0;
    int miscompares = 0;
    int exp_idx = 0;
    logic [8:0] expq [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Expected bytes carry their own last flag from the bench's block position.
    task automatic push_col(input logic [31:0] c);
        logic [7:0] b;
        for (int i = 0; i < 4; i++) begin
            b = c[31-8*i -: 8];
            expq.push_back({exp_idx == 15, b});
            exp_idx = (exp_idx + 1) % 16;
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        logic [8:0] e;
        if (rst_n && out_valid && out_ready) begin
            if (expq.size() == 0) begin
                check("unexpected_out", {24'h0, out_data}, 32'hxxxx_xxxx);
            end else begin
                e = expq.pop_front();
                check("out_data", {24'h0, out_data}, {24'h0, e[7:0]});
                check("out_last", {31'h0, out_last}, {31'h0, e[8]});
            end
        end
    end

    task automatic send(input logic [7:0] b, input logic byp, input int gap);
        int n;
        repeat (gap) begin @(posedge clk); #1; end
        in_valid = 1'b1;
        in_data  = b;
        bypass   = byp;
        n = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 300) begin
                check("in_ready_timeout", 32'd0, 32'd1);
                break;
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send_col(input logic [31:0] c, input logic byp, input int maxgap);
        for (int i = 0; i < 4; i++)
            send(c[31-8*i -: 8], byp, (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((expq.size() != 0 || busy) && n < 2000) begin @(posedge clk); #1; n++; end
        check("drain", expq.size(), 0);
    endtask

    initial begin
        int n, bad_data, bad_rdy;

        // Reset values while reset is held
        @(posedge clk); #1;
        check("rst_in_ready", {31'h0, in_ready}, 0);
        check("rst_out_valid", {31'h0, out_valid}, 0);
        check("rst_out_data", {24'h0, out_data}, 0);
        check("rst_busy", {31'h0, busy}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_in_ready", {31'h0, in_ready}, 1);

        // Block 1: first column latency. The accepting edge closes cycle t;
        // out_valid is visible in cycle t+6, i.e. after 5 more rising edges.
        push_col(MIX_A); push_col(MIX_B); push_col(MIX_C); push_col(MIX_D);
        send_col(COL_A, 1'b0, 0);
        n = 0;
        while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
        check("latency_edges", n, 5);
        send_col(COL_B, 1'b0, 0);
        send_col(COL_C, 1'b0, 0);
        send_col(COL_D, 1'b0, 0);
        wait_drain();

        // Block 2: bypass latched at block start, held though the flag drops.
`ifdef AES_MIXCOL_BYPASS_EN
        push_col(COL_B); push_col(COL_A); push_col(COL_C); push_col(COL_D);
`else
        push_col(MIX_B); push_col(MIX_A); push_col(MIX_C); push_col(MIX_D);
`endif
        send_col(COL_B, 1'b1, 0);
        send_col(COL_A, 1'b0, 0);
        send_col(COL_C, 1'b0, 0);
        send_col(COL_D, 1'b0, 0);
        wait_drain();

        // Block 3: bypass 0 again -> mixed
        push_col(MIX_A); push_col(MIX_B); push_col(MIX_C); push_col(MIX_D);
        send_col(COL_A, 1'b0, 0);
        send_col(COL_B, 1'b0, 0);
        send_col(COL_C, 1'b0, 0);
        send_col(COL_D, 1'b0, 0);
        wait_drain();

        // Block 4: downstream stall; 4th byte of next column must be withheld
        push_col(MIX_A); push_col(MIX_B); push_col(MIX_C); push_col(MIX_D);
        out_ready = 1'b0;
        send_col(COL_A, 1'b0, 0);
        n = 0;
        while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
        send(COL_B[31:24], 1'b0, 0);
        send(COL_B[23:16], 1'b0, 0);
        send(COL_B[15:8],  1'b0, 0);
        in_valid = 1'b1;
        in_data  = COL_B[7:0];
        bad_data = 0;
        bad_rdy  = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_data !== 8'h8e || out_valid !== 1'b1) bad_data++;
            if (in_ready !== 1'b0) bad_rdy++;
        end
        check("stall_hold_cycles_bad", bad_data, 0);
        check("stall_in_ready_cycles_bad", bad_rdy, 0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(COL_B[7:0], 1'b0, 0);
        send_col(COL_C, 1'b0, 0);
        send_col(COL_D, 1'b0, 0);
        wait_drain();

        // Block 5: random input gaps, same results
        push_col(MIX_A); push_col(MIX_B); push_col(MIX_C); push_col(MIX_D);
        send_col(COL_A, 1'b0, 3);
        send_col(COL_B, 1'b0, 3);
        send_col(COL_C, 1'b0, 3);
        send_col(COL_D, 1'b0, 3);
        wait_drain();

        // Reset during FEED cycle 2; that column is discarded
        send_col(COL_A, 1'b0, 0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("midrst_out_valid", {31'h0, out_valid}, 0);
        check("midrst_out_data", {24'h0, out_data}, 0);
        check("midrst_out_last", {31'h0, out_last}, 0);
        check("midrst_busy", {31'h0, busy}, 0);
        check("midrst_in_ready", {31'h0, in_ready}, 0);
        rst_n = 1'b1;
        exp_idx = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (out_valid) check("midrst_stray_out", {31'h0, out_valid}, 0);
        end

        // Fresh block after reset: A is byte 0, last lands on byte 15
        push_col(MIX_A); push_col(MIX_B); push_col(MIX_C); push_col(MIX_D);
        send_col(COL_A, 1'b0, 0);
        send_col(COL_B, 1'b0, 0);
        send_col(COL_C, 1'b0, 0);
        send_col(COL_D, 1'b0, 0);
        wait_drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/mixcol_ctrl.md
# mixcol_ctrl

Byte-serial sequencer for the `mixcolumn_8` MixColumns datapath inside the 8-bit AES round pipeline. It accepts state bytes on a valid/ready stream in column-major order (4 bytes per column, 4 columns per block) and buffers each column. It then feeds the column into `mixcolumn_8` in four uninterrupted cycles with the correct enable mask, captures the four mixed bytes, and replays them on an output valid/ready stream. An optional per-block bypass lets the last AES round pass bytes through unmixed.

## Interface
- No parameters; sizes are fixed constants in `aes_mix_pkg`.
- `clk` in 1: single clock; all logic on the rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `in_valid` in 1: input byte valid.
- `in_ready` out 1: input byte accepted when `in_valid && in_ready`.
- `in_data` in 8: state byte, column-major, byte 0 of column first.
- `bypass` in 1: last-round flag; sampled with byte 0 of column 0 of each block.
- `out_valid` out 1: output byte valid.
- `out_ready` in 1: downstream accepts.
- `out_data` out 8: mixed (or bypassed) byte.
- `out_last` out 1: high on byte 15 of a block.
- `busy` out 1: high in any state other than FILL, or while the output buffer is non-empty.

## Operation
- FSM states:
  - FILL: accept bytes into `ibuf[0..3]`; `in_ready` = 1.
  - FEED: 4 cycles. `din` = `ibuf[k]`; `en` = 8'h00 for k=0 and 8'hFF for k=1..3.
  - CAP: 1 cycle. Load `obuf[0..3]` from `dout0..3`, or from `ibuf` when bypass is latched.
- Transitions:
  - FILL→FEED after the 4th byte is accepted, but only if `obuf` is empty. Otherwise the 4th byte is withheld: `in_ready` = 0 at byte index 3 while `obuf` holds data.
  - FEED→CAP after k=3.
  - CAP→FILL unconditionally.
- The FEED sequence must never stall. `mixcolumn_8` registers update every clock, and `dout` is only valid in the CAP cycle.
- Outside FEED, drive `din` = 8'h00 and `en` = 8'h00.
- `obuf` drains bytes 0..3 in order, one per `out_valid && out_ready`. It becomes empty after byte 3 is taken.
- A byte counter 0..15 tracks the output block and wraps to 0 after `out_last`. A separate input column counter 0..3 wraps after column 3.
- `bypass` is latched at input block start and held for all 4 columns. A bypassed block still traverses FEED and CAP, so timing is identical.
- Reset (including mid-FEED or mid-drain) behaviour:
  - State goes to FILL; all counters go to 0; `ibuf` and `obuf` are cleared; the bypass latch is cleared.
  - `mixcolumn_8` gets `rst = ~rst_n`.
  - Partial columns and blocks are discarded.
- Reset values: `in_ready` 0, `out_valid` 0, `out_data` 8'h00, `out_last` 0, `busy` 0.

## Timing
- 4th input byte accepted in cycle t:
  - FEED occupies t+1..t+4.
  - CAP occurs at t+5.
  - `out_valid` rises at t+6 with byte 0.
- Minimum input-to-output latency is 6 cycles after the last column byte.
- Peak column period is 9 cycles (4 FILL + 4 FEED + 1 CAP).
- Output drain overlaps the next FILL. FEED for the next column waits until `obuf` is empty.
- `out_data`, `out_valid` and `out_last` are registered. `in_ready` is combinational from state, counter and `obuf` occupancy.
- `out_data` is held stable while `out_valid && !out_ready`.

## Configuration
- Macro: `AES_MIXCOL_BYPASS_EN`.
- Defined: bypass behaves as in Operation.
- Undefined: the `bypass` port remains but is ignored, the latch is removed, and CAP always loads from `dout`.

## Structure
- `aes_mix_pkg` holds:
  - state enum `mix_state_e` (FILL, FEED, CAP);
  - `MIX_EN_FIRST` = 8'h00 and `MIX_EN_ACC` = 8'hFF;
  - `COL_BYTES` = 4 and `BLK_COLS` = 4.
- One sub-module: the existing `mixcolumn_8`, instanced once. All sequencing and buffering stay in `mixcol_ctrl`.

## Test plan
- Column db 13 53 45, bypass 0 → out 8e 4d a1 bc; `out_valid` exactly 6 cycles after the 4th accept.
- Full block, columns (db 13 53 45), (f2 0a 22 5c), (01 01 01 01), (c6 c6 c6 c6) → (8e 4d a1 bc), (9f dc 58 9d), (01 01 01 01), (c6 c6 c6 c6); `out_last` only on byte 15.
- Bypass 1 at block start, column f2 0a 22 5c → out f2 0a 22 5c. The next block with bypass 0 is mixed. With the macro undefined, out is 9f dc 58 9d.
- `out_ready` held 0 for 20 cycles after CAP:
  - `out_data` stays 8e;
  - the next column's byte 3 sees `in_ready` = 0 until `obuf` drains;
  - no bytes are lost or reordered.
- Random `in_valid` gaps inside a column → identical outputs to the gap-free run.
- `rst_n` low during FEED cycle 2 → all outputs at reset values next cycle. The following column db 13 53 45 produces 8e 4d a1 bc as byte 0 of a new block.
